// File: rtl/booth_r4_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_multiplier
//
// Sequential radix-4 (modified Booth) multiplier. It retires two multiplier
// bits per clock and supports signed or unsigned operands, selected at run
// time. A zero operand skips straight to completion. The run also stops early
// once every remaining Booth digit is known to be zero.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (aborts any operation)
//   Start        request; accepted only while Ready=1
//   Signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with Start)
//   A            multiplicand, sampled on accept
//   x            multiplier, sampled on accept
//   product      registered 2*L_word-bit result, held until the next completion
//   Ready        high while idle
//   Done         one-cycle pulse; product is valid from this cycle onward
//
// Parameters:
//   L_word       operand width (even, >= 4)
//   L_cnt        digit counter width (2^L_cnt > L_word/2+1)
// ---------------------------------------------------------------------------
module booth_r4_seq_multiplier #(
    parameter int L_word = 8,
    parameter int L_cnt  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic                  Signed_mode,
    input  logic [L_word-1:0]     A,
    input  logic [L_word-1:0]     x,
    output logic [2*L_word-1:0]   product,
    output logic                  Ready,
    output logic                  Done
);

    // The accumulator carries two guard bits above the product width. That
    // way the most-negative multiplicand times a -2 digit cannot overflow.
    localparam int AW = 2*L_word + 2;
    localparam int MW = L_word + 2;
    localparam int N  = L_word/2 + 1;

    typedef enum logic [1:0] {
        S_idle,
        S_run,
        S_done
    } state_t;

    state_t            state;
    logic [AW-1:0]     mcand;
    logic [AW-1:0]     acc;
    logic [MW-1:0]     mreg;
    logic              m_prev;
    logic [L_cnt-1:0]  cnt;

    logic [AW-1:0]     a_ext;
    logic [MW-1:0]     x_ext;
    logic [2:0]        triplet;
    logic [AW-1:0]     addend;
    logic [AW-1:0]     acc_next;
    logic [MW-1:0]     mreg_next;
    logic              m_prev_next;
    logic              early_exit;
    logic              last_digit;

    // Operand extension. The extension bit is 0 in unsigned mode and the sign
    // bit in signed mode. This lets the same Booth recoding give an exact
    // result in both modes.
    always_comb begin
        a_ext = {{(AW-L_word){Signed_mode & A[L_word-1]}}, A};
        x_ext = {{(MW-L_word){Signed_mode & x[L_word-1]}}, x};
    end

    // One Booth digit per cycle. mcand is pre-shifted by two each cycle, so
    // it already equals multiplicand << 2i. The multiplier register shifts
    // arithmetically. Vacated bits therefore repeat the extension bit, which
    // is exactly what the unprocessed upper bits of the extended value are.
    always_comb begin
        triplet = {mreg[1], mreg[0], m_prev};
        addend  = {AW{1'b0}};
        case (triplet)
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = {mcand[AW-2:0], 1'b0};
            3'b100:         addend = {AW{1'b0}} - {mcand[AW-2:0], 1'b0};
            3'b101, 3'b110: addend = {AW{1'b0}} - mcand;
            default:        addend = {AW{1'b0}};
        endcase
        acc_next    = acc + addend;
        mreg_next   = {{2{mreg[MW-1]}}, mreg[MW-1:2]};
        m_prev_next = mreg[1];
        // If every remaining bit equals the retained m[-1], all later
        // triplets are 000 or 111. Every remaining digit is then zero.
        early_exit  = (mreg_next == {MW{m_prev_next}});
        last_digit  = (cnt == L_cnt'(N-1));
    end

    // Control FSM and datapath registers. Ready and Done are registered so
    // they change together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_idle;
            Ready   <= 1'b1;
            Done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mreg    <= '0;
            m_prev  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_idle: begin
                    if (Start) begin
                        mcand  <= a_ext;
                        mreg   <= x_ext;
                        m_prev <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        Ready  <= 1'b0;
                        if (A == '0 || x == '0) begin
                            state   <= S_done;
                            Done    <= 1'b1;
                            product <= '0;
                        end else begin
                            state <= S_run;
                        end
                    end
                end
                S_run: begin
                    acc    <= acc_next;
                    mcand  <= {mcand[AW-3:0], 2'b00};
                    mreg   <= mreg_next;
                    m_prev <= m_prev_next;
                    cnt    <= cnt + L_cnt'(1);
                    if (last_digit || early_exit) begin
                        state   <= S_done;
                        Done    <= 1'b1;
                        product <= acc_next[2*L_word-1:0];
                    end
                end
                S_done: begin
                    state <= S_idle;
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                end
                default: begin
                    state <= S_idle;
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_seq_multiplier
//
// Self-checking bench for booth_r4_seq_multiplier (L_word=8).
//
// A behavioural model predicts Ready, Done and product on every cycle:
//   - the product comes from plain integer multiplication;
//   - the latency comes from the digit-count rule on the extended multiplier.
// Directed cases pin the model to hand-computed values. A random sweep covers
// both modes.
// ---------------------------------------------------------------------------
module tb_booth_r4_seq_multiplier;

    localparam int W = 8;
    localparam int N = W/2 + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             Start;
    logic             Signed_mode;
    logic [W-1:0]     A;
    logic [W-1:0]     x;
    logic [2*W-1:0]   product;
    logic             Ready;
    logic             Done;

    int checks = 0;
    int errors = 0;
    logic compareOn = 1'b0;

    booth_r4_seq_multiplier #(.L_word(W), .L_cnt(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .Signed_mode (Signed_mode),
        .A           (A),
        .x           (x),
        .product     (product),
        .Ready       (Ready),
        .Done        (Done)
    );

    always #5 clk = ~clk;

    // Exact product, truncated to 2*W bits, using ordinary integer arithmetic.
    function automatic logic [2*W-1:0] refProduct(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = sm ? longint'($signed(a)) : longint'(a);
        sb = sm ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[2*W-1:0];
    endfunction

    // Number of Booth digits processed. It is the first i at which every
    // extended multiplier bit from 2i-1 upward is identical.
    function automatic int refDigits(input logic sm, input logic [W-1:0] b);
        longint xe;
        xe = sm ? longint'($signed(b)) : longint'(b);
        for (int i = 1; i <= N; i++) begin
            longint r;
            r = xe >>> (2*i - 1);
            if (r == 0 || r == -1) return i;
        end
        return N;
    endfunction

    // Cycle-level model: idle / busy countdown / done.
    int              mState = 0;
    int              cd = 0;
    logic [2*W-1:0]  expProduct = '0;
    logic [2*W-1:0]  pendProduct = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mState     = 0;
            cd         = 0;
            expProduct = '0;
        end else begin
            case (mState)
                0: if (Start) begin
                    pendProduct = refProduct(Signed_mode, A, x);
                    if (A == '0 || x == '0) begin
                        mState     = 2;
                        expProduct = '0;
                    end else begin
                        cd     = refDigits(Signed_mode, x);
                        mState = 1;
                    end
                end
                1: begin
                    cd = cd - 1;
                    if (cd == 0) begin
                        mState     = 2;
                        expProduct = pendProduct;
                    end
                end
                default: mState = 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (compareOn && !reset) begin
            checkOutput("cyc_ready", 32'(Ready), 32'(mState == 0));
            checkOutput("cyc_done", 32'(Done), 32'(mState == 2));
            checkOutput("cyc_product", 32'(product), 32'(expProduct));
        end
    end

    // Issue one operation starting at a falling edge. Returns the number of
    // cycles from the accept edge until Done is seen.
    task automatic applyStimulus(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard;
        guard = 0;
        while (!Ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!Ready) checkOutput("ready_timeout", 32'(Ready), 32'd1);
        Start       = 1'b1;
        Signed_mode = sm;
        A           = a;
        x           = b;
        @(negedge clk);
        Start = 1'b0;
        lat   = 1;
        while (!Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!Done) checkOutput("done_timeout", 32'(Done), 32'd1);
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           lat;

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'hFF;
            3: return 8'h01;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset       = 1'b1;
        Start       = 1'b0;
        Signed_mode = 1'b0;
        A           = '0;
        x           = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        compareOn = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", 32'(Ready), 32'd1);
        checkOutput("reset_done", 32'(Done), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);

        applyStimulus(1'b1, 8'h80, 8'h80, lat);
        checkOutput("s_min_x_min", 32'(product), 32'h4000);
        checkOutput("s_min_x_min_lat", 32'(lat), 32'd5);

        applyStimulus(1'b0, 8'hFF, 8'hFF, lat);
        checkOutput("u_ff_ff", 32'(product), 32'hFE01);
        checkOutput("u_ff_ff_lat", 32'(lat), 32'd6);

        applyStimulus(1'b1, 8'hFF, 8'hFF, lat);
        checkOutput("s_ff_ff", 32'(product), 32'h0001);
        checkOutput("s_ff_ff_lat", 32'(lat), 32'd2);

        applyStimulus(1'b1, 8'h05, 8'hFD, lat);
        checkOutput("s_5_m3", 32'(product), 32'hFFF1);

        applyStimulus(1'b1, 8'h07, 8'h01, lat);
        checkOutput("s_early", 32'(product), 32'h0007);
        checkOutput("s_early_lat", 32'(lat), 32'd2);

        applyStimulus(1'b0, 8'h07, 8'h01, lat);
        checkOutput("u_early", 32'(product), 32'h0007);
        checkOutput("u_early_lat", 32'(lat), 32'd2);

        applyStimulus(1'b0, 8'h00, 8'h5A, lat);
        checkOutput("zero_bypass", 32'(product), 32'h0000);
        checkOutput("zero_bypass_lat", 32'(lat), 32'd1);

        // Start pulsed during a run must be ignored.
        @(negedge clk);
        Start = 1'b1; Signed_mode = 1'b1; A = 8'h80; x = 8'h80;
        @(negedge clk);
        A = 8'h33; x = 8'h44;
        checkOutput("busy_ready", 32'(Ready), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("busy_ready2", 32'(Ready), 32'd0);
        Start = 1'b0;
        lat = 3;
        while (!Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("busy_ignore_product", 32'(product), 32'h4000);
        checkOutput("busy_ignore_lat", 32'(lat), 32'd5);

        // Reset asserted during the second run cycle aborts the operation.
        @(negedge clk);
        Start = 1'b1; Signed_mode = 1'b0; A = 8'hAB; x = 8'hCD;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_product", 32'(product), 32'd0);
        checkOutput("abort_ready", 32'(Ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort_no_done", 32'(Done), 32'd0);
            @(negedge clk);
        end

        applyStimulus(1'b0, 8'h12, 8'h34, lat);
        checkOutput("u_12_34", 32'(product), 32'h03A8);

        // Random sweep, back-to-back, both modes.
        for (int n = 0; n < 250; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus(rs, ra, rb, lat);
            checkOutput("rand_product", 32'(product), 32'(refProduct(rs, ra, rb)));
            checkOutput("rand_lat", 32'(lat),
                        (ra == '0 || rb == '0) ? 32'd1 : 32'(refDigits(rs, rb) + 1));
        end

        repeat (3) @(negedge clk);
        compareOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_r4_seq_multiplier.md
Name: booth_r4_seq_multiplier

Overview:
- Parametrised successor to the team's radix-2 Booth ASMD multiplier.
- Sequential radix-4 (modified Booth) multiplier that retires two multiplier bits per cycle.
- Runtime signed/unsigned mode, zero-operand bypass, and early termination when the remaining Booth digits are all zero.
- Sits beside the datapath as a multi-cycle arithmetic unit with a Start/Ready/Done handshake.

Parameters:
- L_word, 8, operand width in bits; must be even and at least 4.
- L_cnt, 4, iteration counter width; must satisfy 2^L_cnt > L_word/2+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; accepted only when Ready=1.
- Signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with Start.
- A  input  L_word  multiplicand, sampled on accept.
- x  input  L_word  multiplier, sampled on accept.
- product  output  2*L_word  registered result.
- Ready  output  1  high in S_idle only.
- Done  output  1  one-cycle pulse; product is valid from this cycle onward.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high; it forces state=S_idle, product=0, Done=0, and clears all internal registers. Asserting reset mid-operation aborts the operation; Ready=1 after reset releases.
- States:
  - S_idle: Ready=1.
  - S_run: one Booth digit per cycle.
  - S_done: Done=1 for exactly one cycle, then S_idle.
- Accept: Start=1 in S_idle at a rising edge latches A, x and Signed_mode.
  - If A==0 or x==0: next state is S_done, the accumulator is cleared, product=0.
  - Otherwise: next state is S_run.
  - Start outside S_idle is ignored; there is no queueing.
- Operand extension:
  - Multiplicand is sign-extended (Signed_mode=1) or zero-extended (Signed_mode=0) to 2*L_word+2 bits.
  - Multiplier is extended to L_word+2 bits the same way, with an implicit 0 appended below bit 0.
  - N = L_word/2+1 digits maximum.
- Recoding: digit i is taken from triplet {m[2i+1], m[2i], m[2i-1]}.
  - 000 and 111 → 0
  - 001 and 010 → +1
  - 011 → +2
  - 100 → -2
  - 101 and 110 → -1
  - The ±2 digit uses the multiplicand shifted left by 1. Subtraction is two's complement in a (2*L_word+2)-bit accumulator.
- S_run, per cycle:
  - acc += digit × (multiplicand << 2i).
  - Shift the multiplier register right by 2, keeping the last shifted-out bit as the new m[-1].
  - Increment the counter.
- Leaving S_run (go to S_done at that edge) when either:
  - the counter reaches N, or
  - early termination: after the current digit, all unprocessed extended multiplier bits and the retained m[-1] are equal, so every remaining digit is 0.
- Result: product <= acc[2*L_word-1:0] on the edge entering S_done. This is exact for both modes. product holds until the next accepted Start completes.
- Latency:
  - Zero operand: Done in the cycle after the accept edge.
  - Otherwise: Done after k+1 cycles, where k is the number of S_run cycles, 1 ≤ k ≤ N.
- Back-to-back: Start may be asserted in the cycle after Done (the S_idle cycle). The minimum issue interval is k+2 cycles.
- Signed extremes must be exact:
  - -2^(L_word-1) × -2^(L_word-1) = 2^(2*L_word-2).
  - The most-negative multiplicand with a -2 digit must not overflow the accumulator (guaranteed by the +2 guard bits).

Test Plan (L_word=8):
- Signed_mode=1, A=0x80, x=0x80 → product=0x4000; Done after N+1=6 cycles at most.
- Signed_mode=0, A=0xFF, x=0xFF → product=0xFE01. Signed_mode=1 with the same operands → product=0x0001.
- Signed_mode=1, A=0x05, x=0xFD (-3) → product=0xFFF1.
- Early termination:
  - Signed_mode=1, A=0x07, x=0x01 → product=0x0007, Done 2 cycles after accept (k=1).
  - Signed_mode=0, A=0x07, x=0x01 → product=0x0007 with early exit, k=1.
- Zero bypass: A=0x00, x=0x5A → Done the cycle after accept, product=0x0000. Start pulsed in S_run → ignored; Ready stays 0 until S_idle.
- Reset mid-run, asserted at cycle 2 of S_run → product=0, Ready=1, no Done pulse. A new operation 0x12×0x34 unsigned → product=0x03A8. Finally, random sweep in both modes against a reference model.
